// File: rtl/flp_adder_norm_stage.sv
// Second stage of the pseudo-softmax FP adder: leading-one normalisation, exponent saturation and vector tracking.
// Optional FLP_NORM_SAT_STICKY_EN adds vec_sat, a per-vector sticky OR of out_sat.
module flp_adder_norm_stage #(
  parameter int EXP_W     = 9,
  parameter int MANT_W    = 8,
  parameter int OUT_EXP_W = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W-1:0]     in_exp,
  input  logic [MANT_W-1:0]    in_mant,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_EXP_W-1:0] out_exp,
  output logic [MANT_W-1:0]    out_mant,
  output logic                 out_zero,
  output logic                 out_sat,
  output logic                 out_last,
  output logic [CNT_W-1:0]     out_count
`ifdef FLP_NORM_SAT_STICKY_EN
  ,
  output logic                 vec_sat
`endif
);

  localparam int POS_W = (MANT_W > 1) ? $clog2(MANT_W) : 1;

  logic              v1;
  logic [EXP_W-1:0]  exp1;
  logic [MANT_W-1:0] mant1;
  logic [POS_W-1:0]  pos1;
  logic              zero1;
  logic              last1;
  logic [CNT_W-1:0]  cnt1;
  logic [CNT_W-1:0]  elem_cnt;

  logic              s2_load;
  logic              accept;
  logic [POS_W-1:0]  lead_pos;
  logic [POS_W-1:0]  shamt;
  logic [EXP_W:0]    exp_sum;
  logic              exp_ovf;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !v1 || s2_load;
  assign accept   = in_valid && in_ready;

  // Highest set bit wins; the value is irrelevant for a zero mantissa.
  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < MANT_W; i++) begin
      if (in_mant[i]) lead_pos = POS_W'(i);
    end
  end

  assign shamt   = POS_W'(MANT_W - 1) - pos1;
  assign exp_sum = (EXP_W+1)'(exp1) + (EXP_W+1)'(pos1);
  assign exp_ovf = exp_sum > (EXP_W+1)'({OUT_EXP_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      exp1     <= '0;
      mant1    <= '0;
      pos1     <= '0;
      zero1    <= 1'b0;
      last1    <= 1'b0;
      cnt1     <= '0;
      elem_cnt <= '0;
    end else begin
      if (accept) begin
        v1       <= 1'b1;
        exp1     <= in_exp;
        mant1    <= in_mant;
        pos1     <= lead_pos;
        zero1    <= (in_mant == '0);
        last1    <= in_last;
        cnt1     <= elem_cnt + CNT_W'(1);
        elem_cnt <= in_last ? '0 : elem_cnt + CNT_W'(1);
      end else if (s2_load) begin
        v1 <= 1'b0;
      end
    end
  end

  // Output data only moves when a real word arrives, so idle inputs never reach the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_exp   <= '0;
      out_mant  <= '0;
      out_zero  <= 1'b0;
      out_sat   <= 1'b0;
      out_last  <= 1'b0;
      out_count <= '0;
    end else if (s2_load) begin
      out_valid <= v1;
      if (v1) begin
        out_last  <= last1;
        out_count <= cnt1;
        out_zero  <= zero1;
        if (zero1) begin
          out_mant <= '0;
          out_exp  <= '0;
          out_sat  <= 1'b0;
        end else begin
          out_mant <= mant1 << shamt;
          out_exp  <= exp_ovf ? {OUT_EXP_W{1'b1}} : exp_sum[OUT_EXP_W-1:0];
          out_sat  <= exp_ovf;
        end
      end
    end
  end

`ifdef FLP_NORM_SAT_STICKY_EN
  logic sat_acc;

  // Accumulates earlier words of the vector; the current word is ORed in combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_acc <= 1'b0;
    end else if (out_valid && out_ready) begin
      sat_acc <= out_last ? 1'b0 : (sat_acc || out_sat);
    end
  end

  assign vec_sat = sat_acc || (out_valid && out_sat);
`endif

endmodule

// File: tb/tb_flp_adder_norm_stage.sv
// Randomised self-checking bench for flp_adder_norm_stage with a queue-based arithmetic reference model.
// Honours FLP_NORM_SAT_STICKY_EN when defined.
module tb_flp_adder_norm_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_exp;
  logic [7:0] in_mant;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_exp;
  logic [7:0] out_mant;
  logic       out_zero;
  logic       out_sat;
  logic       out_last;
  logic [7:0] out_count;
`ifdef FLP_NORM_SAT_STICKY_EN
  logic       vec_sat;
`endif

  flp_adder_norm_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
    .out_zero  (out_zero),
    .out_sat   (out_sat),
    .out_last  (out_last),
    .out_count (out_count)
`ifdef FLP_NORM_SAT_STICKY_EN
    ,
    .vec_sat   (vec_sat)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] e;
    logic [7:0] m;
    logic       z;
    logic       s;
    logic       l;
    logic [7:0] c;
    logic       vs;
  } word_t;

  word_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    accept_count = 0;
  int    model_idx = 0;
  logic  model_vsat = 1'b0;
  int    ready_mode = 0;
  int    phase = 0;
  logic  stall_prev = 1'b0;
  logic [26:0] prev_out;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: value = mant * 2^exp rewritten as (m/128) * 2^e using plain arithmetic.
  function automatic word_t model_word(input int e_in, input int m_in, input logic last);
    word_t w;
    int p, v, e;
    w.z = (m_in == 0);
    w.l = last;
    w.c = 8'((model_idx + 1) % 256);
    if (m_in == 0) begin
      w.e = 0; w.m = 0; w.s = 0;
    end else begin
      p = 0; v = m_in;
      while (v > 1) begin v = v / 2; p++; end
      w.m = 8'(m_in * (2 ** (7 - p)));
      e = e_in + p;
      w.s = (e > 255);
      w.e = w.s ? 8'd255 : 8'(e);
    end
    w.vs = 1'b0;
    return w;
  endfunction

  // Driven #2 after each edge so it never races inputs driven at #1.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = ((phase % 4) == 0) || ((phase % 4) == 3); phase++; end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Signals are stable at the falling edge and describe the transfer at the next rising edge.
  always @(negedge clk) begin
    word_t w;
    if (!rst_n) begin
      exp_q.delete();
      model_idx  = 0;
      model_vsat = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_hold", 32'({out_exp, out_mant, out_zero, out_sat, out_last, out_count}), 32'(prev_out));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_out", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          checkOutput("out_exp", 32'(out_exp), 32'(w.e));
          checkOutput("out_mant", 32'(out_mant), 32'(w.m));
          checkOutput("out_zero", 32'(out_zero), 32'(w.z));
          checkOutput("out_sat", 32'(out_sat), 32'(w.s));
          checkOutput("out_last", 32'(out_last), 32'(w.l));
          checkOutput("out_count", 32'(out_count), 32'(w.c));
`ifdef FLP_NORM_SAT_STICKY_EN
          if (w.l) checkOutput("vec_sat", 32'(vec_sat), 32'(w.vs));
`endif
        end
      end
      if (in_valid && in_ready) begin
        accept_count++;
        w = model_word(int'(in_exp), int'(in_mant), in_last);
        model_vsat = model_vsat | w.s;
        w.vs = model_vsat;
        if (in_last) begin
          model_idx  = 0;
          model_vsat = 1'b0;
        end else begin
          model_idx++;
        end
        exp_q.push_back(w);
      end
      stall_prev = out_valid && !out_ready;
      prev_out   = {out_exp, out_mant, out_zero, out_sat, out_last, out_count};
    end
  end

  // Holds one word until accepted, with a bounded wait.
  task automatic applyStimulus(input logic [8:0] e, input logic [7:0] m, input logic last);
    logic ok;
    in_valid = 1'b1; in_exp = e; in_mant = m; in_last = last;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      if (ok) begin
        in_valid = 1'b0; in_exp = 'x; in_mant = 'x; in_last = 1'b0;
        return;
      end
    end
    checkOutput("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic randomWord(output logic [8:0] e, output logic [7:0] m, input int last_pct);
    e = 9'($urandom_range(0, 3) == 0 ? $urandom_range(248, 511) : $urandom_range(0, 511));
    m = 8'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 255));
  endtask

  initial begin
    logic [8:0] e;
    logic [7:0] m;
    logic       ok;
    int         start;

    rst_n = 1'b0; in_valid = 1'b0; in_exp = 'x; in_mant = 'x; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", 32'({out_exp, out_mant, out_zero, out_sat, out_last, out_count}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    // Single-word latency and directed values
    applyStimulus(9'd10, 8'd1, 1'b1);
    checkOutput("lat_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("lat_valid", 32'(out_valid), 32'd1);
    checkOutput("lat_mant", 32'(out_mant), 32'h80);
    checkOutput("lat_exp", 32'(out_exp), 32'd10);
    checkOutput("lat_count", 32'(out_count), 32'd1);
    applyStimulus(9'd20, 8'd2, 1'b1);
    applyStimulus(9'd255, 8'h81, 1'b1);
    @(posedge clk); #1;
    checkOutput("sat_exp", 32'(out_exp), 32'd255);
    checkOutput("sat_flag", 32'(out_sat), 32'd1);
    applyStimulus(9'd77, 8'd0, 1'b1);
    @(posedge clk); #1;
    checkOutput("zero_flag", 32'(out_zero), 32'd1);
    repeat (3) @(posedge clk);

    // Stalling pattern 1,0,0,1 over a 4-word vector, then a fresh vector
    @(posedge clk); ready_mode = 1; #1;
    for (int i = 0; i < 4; i++) begin randomWord(e, m, 0); applyStimulus(e, m, i == 3); end
    for (int i = 0; i < 2; i++) begin randomWord(e, m, 0); applyStimulus(e, m, i == 1); end
    repeat (10) @(posedge clk);

    // Full backpressure: exactly two words fit before in_ready drops
    ready_mode = 3;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    start = accept_count;
    randomWord(e, m, 0);
    in_valid = 1'b1; in_exp = e; in_mant = m; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      if (ok) begin randomWord(e, m, 0); in_exp = e; in_mant = m; end
    end
    checkOutput("bp_accepts", 32'(accept_count - start), 32'd2);
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    ready_mode = 0;
    start = accept_count;
    for (int i = 0; i < 8; i++) begin
      in_last = (i == 7);
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      if (ok) begin randomWord(e, m, 0); in_exp = e; in_mant = m; end
    end
    in_valid = 1'b0; in_last = 1'b0;
    checkOutput("thru_accepts", 32'(accept_count - start), 32'd8);
    repeat (6) @(posedge clk);

    // Mid-stream reset with both stages occupied
    ready_mode = 3;
    @(posedge clk); #1;
    randomWord(e, m, 0); applyStimulus(e, m, 1'b0);
    randomWord(e, m, 0); applyStimulus(e, m, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1; ready_mode = 0;
    applyStimulus(9'd3, 8'd5, 1'b1);
    repeat (4) @(posedge clk);

    // Counter wrap on a long vector
    #1;
    for (int i = 0; i < 260; i++) begin randomWord(e, m, 0); applyStimulus(e, m, i == 259); end

    // Random traffic with random backpressure and short vectors
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      randomWord(e, m, 0);
      applyStimulus(e, m, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    ready_mode = 0;

    start = 0;
    while (exp_q.size() != 0 && start < 1000) begin @(posedge clk); start++; end
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
